// File: rtl/window_gen_3x3_if.sv
// Pixel-stream in / 3x3-window out bundle for window_gen_3x3.
// Data_In/Valid_In    : raster-order pixel words from the producer.
// Data_Out0..8        : window, row-major, 0 = top-left, 8 = newest pixel.
// Valid_Out           : one-cycle strobe, Data_Out0..8 hold a valid window.
// Frame_Done          : one-cycle strobe, last pixel of a frame accepted.
// master = stream producer / window consumer, slave = window_gen_3x3.
interface window_gen_3x3_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Valid_In;
    logic [DATA_WIDTH-1:0] Data_Out0;
    logic [DATA_WIDTH-1:0] Data_Out1;
    logic [DATA_WIDTH-1:0] Data_Out2;
    logic [DATA_WIDTH-1:0] Data_Out3;
    logic [DATA_WIDTH-1:0] Data_Out4;
    logic [DATA_WIDTH-1:0] Data_Out5;
    logic [DATA_WIDTH-1:0] Data_Out6;
    logic [DATA_WIDTH-1:0] Data_Out7;
    logic [DATA_WIDTH-1:0] Data_Out8;
    logic                  Valid_Out;
    logic                  Frame_Done;

    modport master (
        output Data_In, Valid_In,
        input  Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
               Data_Out5, Data_Out6, Data_Out7, Data_Out8,
               Valid_Out, Frame_Done
    );

    modport slave (
        input  Data_In, Valid_In,
        output Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
               Data_Out5, Data_Out6, Data_Out7, Data_Out8,
               Valid_Out, Frame_Done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator feeding the max-pooling comparator tree.
// Two line buffers (LB0 = row r-1, LB1 = row r-2) plus a 3x3 shift window;
// complete windows are emitted every STRIDE columns/rows with registered outputs.
// Ports: clk (rising edge), rst (async, active-low), bus (window_gen_3x3_if.slave).
module window_gen_3x3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16,
    parameter int unsigned STRIDE     = 2
) (
    input  logic            clk,
    input  logic            rst,
    window_gen_3x3_if.slave bus
);
    localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned PW = 2;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [PW-1:0]         col_ph;
    logic [PW-1:0]         row_ph;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win     [9];
    logic [DATA_WIDTH-1:0] win_nxt [9];
    logic [DATA_WIDTH-1:0] dout    [9];
    logic                  valid_out;
    logic                  frame_done;

    logic                  beat;
    logic                  col_last;
    logic                  row_last;
    logic [PW-1:0]         col_ph_cur;
    logic [PW-1:0]         row_ph_cur;
    logic [PW-1:0]         col_ph_nxt;
    logic [PW-1:0]         row_ph_nxt;
    logic                  emit;

    // Position decode; phases are forced to 0 at the first full-window column/row.
    always_comb begin
        beat       = bus.Valid_In;
        col_last   = (col == CW'(IMG_WIDTH - 1));
        row_last   = (row == RW'(IMG_HEIGHT - 1));
        col_ph_cur = (col == CW'(2)) ? '0 : col_ph;
        row_ph_cur = (row == RW'(2)) ? '0 : row_ph;
        col_ph_nxt = (col_ph_cur == PW'(STRIDE - 1)) ? '0 : col_ph_cur + PW'(1);
        row_ph_nxt = (row_ph_cur == PW'(STRIDE - 1)) ? '0 : row_ph_cur + PW'(1);
        emit       = beat && (row >= RW'(2)) && (col >= CW'(2)) &&
                     (row_ph_cur == '0) && (col_ph_cur == '0);
    end

    // Next window: shift columns left, new right column = {LB1, LB0, Data_In}.
    always_comb begin
        win_nxt = win;
        for (int i = 0; i < 3; i++) begin
            win_nxt[3*i]   = win[3*i+1];
            win_nxt[3*i+1] = win[3*i+2];
        end
        win_nxt[2] = lb1[col];
        win_nxt[5] = lb0[col];
        win_nxt[8] = bus.Data_In;
    end

    // Line buffers and window shift register; contents need no reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.Data_In;
            win      <= win_nxt;
        end
    end

    // Raster position and stride-phase counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (beat) begin
            col    <= col_last ? '0 : col + CW'(1);
            col_ph <= col_ph_nxt;
            if (col_last) begin
                row    <= row_last ? '0 : row + RW'(1);
                row_ph <= row_ph_nxt;
            end
        end
    end

    // Registered window outputs and strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                dout[i] <= '0;
            end
        end else begin
            valid_out  <= emit;
            frame_done <= beat && col_last && row_last;
            if (emit) begin
                dout <= win_nxt;
            end
        end
    end

    assign bus.Data_Out0  = dout[0];
    assign bus.Data_Out1  = dout[1];
    assign bus.Data_Out2  = dout[2];
    assign bus.Data_Out3  = dout[3];
    assign bus.Data_Out4  = dout[4];
    assign bus.Data_Out5  = dout[5];
    assign bus.Data_Out6  = dout[6];
    assign bus.Data_Out7  = dout[7];
    assign bus.Data_Out8  = dout[8];
    assign bus.Valid_Out  = valid_out;
    assign bus.Frame_Done = frame_done;
endmodule
